gpio_stream_bridge: RTL

Word-to-byte bridge between the CW305 register block and the Pulpino GPIO byte handshake, running entirely on `pulpino_clk`. Host-written 32-bit words are buffered in a small FIFO and sent to Pulpino one byte at a time over a toggle-token handshake. Bytes coming back from Pulpino are packed into 32-bit words for host readback. It sits between the USB register front-end and the Pulpino `gpio_in`/`gpio_out` bus.

---
 rtl/gpio_bridge_pkg.sv | 14 +
 rtl/sync_word_fifo.sv | 58 +++++
 rtl/gpio_stream_bridge.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/gpio_bridge_pkg.sv
// rtl/gpio_bridge_pkg.sv - shared types and constants for the GPIO word/byte bridge
package gpio_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    SEND     = 2'd2,
    WAIT_ACK = 2'd3
  } tx_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = 2;

endpackage

// File: rtl/sync_word_fifo.sv
// rtl/sync_word_fifo.sv - single-clock word FIFO with registered head-of-queue output
module sync_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra MSB so full and empty are distinguishable when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointer update, wrapping naturally modulo 2*DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Head word is re-registered every cycle; it is valid one cycle after the FIFO turns non-empty
  // or after a pop, which the consumer's state sequence always allows for.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: rtl/gpio_stream_bridge.sv
// rtl/gpio_stream_bridge.sv - host word FIFO to Pulpino byte toggle-handshake bridge, both directions
module gpio_stream_bridge
  import gpio_bridge_pkg::*;
#(
  parameter int pFIFO_DEPTH = 4,
  parameter int pWORD_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [31:0] tx_word_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [31:0] rx_word_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [7:0]  gpio_data_in_o,
  output logic        in_io_turn_o,
  input  logic        in_pulpino_turn_i,
  input  logic [7:0]  gpio_data_out_i,
  input  logic        out_pulpino_turn_i,
  output logic        out_io_turn_o,
  output logic        tx_busy_o
);

  tx_state_t              tx_state;
  tx_state_t              tx_next;
  logic [31:0]            fifo_rd_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic                   ready_q;
  logic [31:0]            tx_shift;
  logic [BYTE_CNT_W-1:0]  tx_cnt;
  logic                   load_shift;
  logic                   do_send;
  logic                   do_shift;
  logic                   tx_acked;
  logic                   tx_last;

  logic [BYTE_CNT_W-1:0]  rx_cnt;
  logic [23:0]            rx_buf;
  logic                   rx_pending;
  logic                   rx_last;
  logic                   rx_accept;

  // ready_q keeps tx_ready_o low while reset is asserted and until the first clock after release.
  assign tx_ready_o = ready_q && !fifo_full;
  assign tx_busy_o  = !fifo_empty || (tx_state != IDLE);

  sync_word_fifo #(
    .DEPTH (pFIFO_DEPTH),
    .WIDTH (32)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (reset_i),
    .push    (tx_valid_i && tx_ready_o),
    .wr_data (tx_word_i),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tx_acked = (in_pulpino_turn_i == in_io_turn_o);
  assign tx_last  = (tx_cnt == BYTE_CNT_W'(pWORD_BYTES - 1));

  // TX state register.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      tx_state <= IDLE;
    end else begin
      tx_state <= tx_next;
    end
  end

  // TX next-state and datapath strobes.
  always_comb begin
    tx_next    = tx_state;
    fifo_pop   = 1'b0;
    load_shift = 1'b0;
    do_send    = 1'b0;
    do_shift   = 1'b0;
    case (tx_state)
      IDLE: begin
        if (!fifo_empty) tx_next = LOAD;
      end
      LOAD: begin
        fifo_pop   = 1'b1;
        load_shift = 1'b1;
        tx_next    = SEND;
      end
      SEND: begin
        do_send = 1'b1;
        tx_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_acked) begin
          if (tx_last) begin
            tx_next = fifo_empty ? IDLE : LOAD;
          end else begin
            do_shift = 1'b1;
            tx_next  = SEND;
          end
        end
      end
      default: tx_next = IDLE;
    endcase
  end

  // TX datapath: word shift register, byte counter, presented byte and outgoing token.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      ready_q        <= 1'b0;
      tx_shift       <= '0;
      tx_cnt         <= '0;
      gpio_data_in_o <= '0;
      in_io_turn_o   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (load_shift) begin
        tx_shift <= fifo_rd_data;
        tx_cnt   <= '0;
      end else if (do_shift) begin
        tx_shift <= {8'h00, tx_shift[31:8]};
        tx_cnt   <= tx_cnt + 1'b1;
      end
      if (do_send) begin
        gpio_data_in_o <= tx_shift[7:0];
        in_io_turn_o   <= ~in_io_turn_o;
      end
    end
  end

  // The last byte of a word is held off (left unacknowledged) while the previous word is still
  // unread, unless the host is reading it in this very cycle.
  assign rx_pending = (out_pulpino_turn_i != out_io_turn_o);
  assign rx_last    = (rx_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  assign rx_accept  = rx_pending && (!rx_last || !rx_valid_o || rx_ready_i);

  // RX assembler: capture bytes LSB first, publish the word on the last byte.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      rx_cnt        <= '0;
      rx_buf        <= '0;
      rx_word_o     <= '0;
      rx_valid_o    <= 1'b0;
      out_io_turn_o <= 1'b0;
    end else begin
      if (rx_accept) begin
        out_io_turn_o <= out_pulpino_turn_i;
        rx_cnt        <= rx_cnt + 1'b1;
        case (rx_cnt)
          2'd0:    rx_buf[7:0]   <= gpio_data_out_i;
          2'd1:    rx_buf[15:8]  <= gpio_data_out_i;
          2'd2:    rx_buf[23:16] <= gpio_data_out_i;
          default: ;
        endcase
      end
      if (rx_accept && rx_last) begin
        rx_word_o  <= {gpio_data_out_i, rx_buf};
        rx_valid_o <= 1'b1;
      end else if (rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule
